// File: rtl/i2c_byte_seq.sv
// ---------------------------------------------------------------------------
// i2c_byte_seq
//
// Byte-level I2C sequencer. It accepts one byte operation (START, WRITE,
// READ, STOP), expands it into a list of bit commands for a downstream bit
// engine, and for READ/ACK commands samples SDA on the next rising SCL edge
// seen on the (synchronized) bus.
//
// Optional build macro: I2C_BYTE_SEQ_TIMEOUT_EN adds a watchdog that aborts
// an op stuck in ISSUE/WAIT_SMP for TIMEOUT_CYC cycles.
//
// Ports
//   clock, rst_n          system clock, synchronous active-low reset
//   op_vld/op/op_data     byte-operation request (op: 0 START 1 WRITE
//   op_last               2 READ 3 STOP); op_last selects NACK after READ
//   op_mid/op_proc_id     tags forwarded with every bit command
//   op_ready, op_done     accept handshake / one-cycle completion pulse
//   rd_data, ack_err      received byte / slave NACK on the last WRITE
//   timeout_err           watchdog abort flag (0 without the macro)
//   cmd_vld/cmd/cmd_ready bit-command handshake to the bit engine
//   cmd_mid/cmd_proc_id   tags of the presented command
//   scl_i, sda_i          asynchronous bus inputs
// ---------------------------------------------------------------------------
package parameter_package;
   localparam logic [3:0] CMD_IDLE  = 4'd0;
   localparam logic [3:0] CMD_START = 4'd1;
   localparam logic [3:0] CMD_STOP  = 4'd2;
   localparam logic [3:0] CMD_0     = 4'd3;
   localparam logic [3:0] CMD_1     = 4'd4;
   localparam logic [3:0] CMD_L0    = 4'd5;
   localparam logic [3:0] CMD_L1    = 4'd6;
   localparam logic [3:0] CMD_RD    = 4'd7;
   localparam logic [3:0] CMD_ACK   = 4'd8;
   localparam logic [3:0] CMD_MACK  = 4'd9;
endpackage

module i2c_byte_seq
   import parameter_package::*;
#(
   parameter int CSIZE       = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             op_vld,
   input  logic [1:0]       op,
   input  logic [7:0]       op_data,
   input  logic             op_last,
   input  logic [3:0]       op_mid,
   input  logic [1:0]       op_proc_id,
   output logic             op_ready,
   output logic             op_done,
   output logic [7:0]       rd_data,
   output logic             ack_err,
   output logic             timeout_err,
   output logic             cmd_vld,
   output logic [CSIZE-1:0] cmd,
   input  logic             cmd_ready,
   output logic [3:0]       cmd_mid,
   output logic [1:0]       cmd_proc_id,
   input  logic             scl_i,
   input  logic             sda_i
);

   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_STOP  = 2'd3;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_ISSUE    = 3'd2;
   localparam logic [2:0] S_WAIT_SMP = 3'd3;
   localparam logic [2:0] S_NEXT     = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   // Bit command at position idx of the op's command list.
   function automatic logic [3:0] cmd_for(input logic [1:0] o, input logic [7:0] d,
                                          input logic l, input logic [3:0] idx);
      logic [3:0] c;
      c = CMD_IDLE;
      case (o)
         OP_START: c = CMD_START;
         OP_STOP:  c = CMD_STOP;
         OP_WRITE: begin
            if (idx < 4'd7)       c = d[3'd7 - idx[2:0]] ? CMD_1 : CMD_0;
            else if (idx == 4'd7) c = d[0] ? CMD_L1 : CMD_L0;
            else                  c = CMD_ACK;
         end
         default:  c = (idx < 4'd8) ? CMD_RD : (l ? CMD_1 : CMD_MACK);
      endcase
      return c;
   endfunction

   logic [2:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [7:0]       data_q, data_d;
   logic             last_q, last_d;
   logic [3:0]       mid_q, mid_d;
   logic [1:0]       pid_q, pid_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic             cmd_vld_q, cmd_vld_d;
   logic [CSIZE-1:0] cmd_q, cmd_d;
   logic [3:0]       cmd_mid_q, cmd_mid_d;
   logic [1:0]       cmd_pid_q, cmd_pid_d;
   logic             op_done_q, op_done_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             ack_err_q, ack_err_d;
   logic             armed_q, armed_d;
   logic [1:0]       scl_sync_q, sda_sync_q;
   logic             scl_prev_q;

   logic       scl_rise, smp_take, sda_s, is_smp_cmd, accept;
   logic [3:0] n_cmds;

   assign sda_s      = sda_sync_q[1];
   assign scl_rise   = scl_sync_q[1] & ~scl_prev_q;
   // Only a flag armed on an earlier edge may sample, so an SCL rise in the
   // same cycle as the RD/ACK transfer is never taken as that bit.
   assign smp_take   = armed_q & scl_rise;
   assign is_smp_cmd = (cmd_q == CSIZE'(CMD_RD)) || (cmd_q == CSIZE'(CMD_ACK));
   assign n_cmds     = (op_q == OP_START || op_q == OP_STOP) ? 4'd1 : 4'd9;
   assign accept     = (state_q == S_IDLE) && op_vld;

`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_err_q, timeout_err_d;
   logic            wd_hit;
   assign wd_hit = (state_q == S_ISSUE || state_q == S_WAIT_SMP) &&
                   (wd_q == WD_W'(TIMEOUT_CYC - 1));
`endif

   always_comb begin
      // NOTE: every _d starts from its _q (or a pulse default), so no branch
      // below can leave a signal unassigned and infer a latch.
      state_d   = state_q;   op_d      = op_q;      data_d    = data_q;
      last_d    = last_q;    mid_d     = mid_q;     pid_d     = pid_q;
      bit_idx_d = bit_idx_q; cmd_vld_d = cmd_vld_q; cmd_d     = cmd_q;
      cmd_mid_d = cmd_mid_q; cmd_pid_d = cmd_pid_q; op_done_d = 1'b0;
      shift_d   = shift_q;   rd_data_d = rd_data_q; ack_err_d = ack_err_q;
      armed_d   = armed_q;
      case (state_q)
         S_IDLE: if (accept) begin
            op_d = op; data_d = op_data; last_d = op_last;
            mid_d = op_mid; pid_d = op_proc_id;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            bit_idx_d = 4'd0;
            cmd_d     = CSIZE'(cmd_for(op_q, data_q, last_q, 4'd0));
            cmd_mid_d = mid_q;
            cmd_pid_d = pid_q;
            cmd_vld_d = 1'b1;
            state_d   = S_ISSUE;
         end
         S_ISSUE: if (cmd_ready) begin
            cmd_vld_d = 1'b0;
            bit_idx_d = bit_idx_q + 4'd1;
            if (is_smp_cmd) begin
               armed_d = 1'b1;
               state_d = S_WAIT_SMP;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_WAIT_SMP: if (smp_take) begin
            armed_d = 1'b0;
            state_d = S_NEXT;
            if (cmd_q == CSIZE'(CMD_ACK)) begin
               ack_err_d = sda_s;
            end else begin
               shift_d = {shift_q[6:0], sda_s};
               // The byte is published once, after the eighth sample.
               if (bit_idx_q == 4'd8) rd_data_d = {shift_q[6:0], sda_s};
            end
         end
         S_NEXT: begin
            if (bit_idx_q < n_cmds) begin
               cmd_d     = CSIZE'(cmd_for(op_q, data_q, last_q, bit_idx_q));
               cmd_vld_d = 1'b1;
               state_d   = S_ISSUE;
            end else begin
               op_done_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
      timeout_err_d = accept ? 1'b0 : timeout_err_q;
      if (wd_hit) begin
         timeout_err_d = 1'b1;
         cmd_vld_d     = 1'b0;
         armed_d       = 1'b0;
         op_done_d     = 1'b1;
         state_d       = S_IDLE;
      end
      // Counts consecutive cycles spent in one waiting state.
      if (state_d != state_q || !(state_q == S_ISSUE || state_q == S_WAIT_SMP))
         wd_d = '0;
      else
         wd_d = wd_q + 1'b1;
`endif
   end

   // NOTE: state updates use non-blocking assignments and the reset is
   // sampled on the clock edge (synchronous), matching the rest of the chip.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;     op_q      <= 2'd0;  data_q    <= 8'd0;
         last_q     <= 1'b0;       mid_q     <= 4'd0;  pid_q     <= 2'd0;
         bit_idx_q  <= 4'd0;       cmd_vld_q <= 1'b0;
         cmd_q      <= CSIZE'(CMD_IDLE);
         cmd_mid_q  <= 4'd0;       cmd_pid_q <= 2'd0;  op_done_q <= 1'b0;
         shift_q    <= 8'd0;       rd_data_q <= 8'd0;  ack_err_q <= 1'b0;
         armed_q    <= 1'b0;
         scl_sync_q <= 2'b11;      sda_sync_q <= 2'b11; scl_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;    op_q      <= op_d;      data_q    <= data_d;
         last_q     <= last_d;     mid_q     <= mid_d;     pid_q     <= pid_d;
         bit_idx_q  <= bit_idx_d;  cmd_vld_q <= cmd_vld_d; cmd_q     <= cmd_d;
         cmd_mid_q  <= cmd_mid_d;  cmd_pid_q <= cmd_pid_d; op_done_q <= op_done_d;
         shift_q    <= shift_d;    rd_data_q <= rd_data_d; ack_err_q <= ack_err_d;
         armed_q    <= armed_d;
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_prev_q <= scl_sync_q[1];
      end
   end

`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wd_q          <= wd_d;
         timeout_err_q <= timeout_err_d;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign op_ready    = (state_q == S_IDLE);
   assign op_done     = op_done_q;
   assign rd_data     = rd_data_q;
   assign ack_err     = ack_err_q;
   assign cmd_vld     = cmd_vld_q;
   assign cmd         = cmd_q;
   assign cmd_mid     = cmd_mid_q;
   assign cmd_proc_id = cmd_pid_q;

endmodule

// File: tb/tb_i2c_byte_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_seq
//
// Self-checking bench for i2c_byte_seq. A table of byte operations with
// hand-computed command lists and result bytes is applied in a loop; a bus
// model acts as bit engine (cmd_ready) and slave (SCL pulse + SDA bit after
// every RD/ACK transfer). Hand-written sequences cover reset mid-op and the
// watchdog (or unbounded waiting when I2C_BYTE_SEQ_TIMEOUT_EN is undefined).
// ---------------------------------------------------------------------------
module tb_i2c_byte_seq;
   import parameter_package::*;

   localparam int CSIZE = 4;
   localparam int TO    = 16;

   logic             clock = 1'b0;
   logic             rst_n = 1'b0;
   logic             op_vld = 1'b0;
   logic [1:0]       op = 2'd0;
   logic [7:0]       op_data = 8'd0;
   logic             op_last = 1'b0;
   logic [3:0]       op_mid = 4'd0;
   logic [1:0]       op_proc_id = 2'd0;
   logic             op_ready, op_done, ack_err, timeout_err, cmd_vld;
   logic [7:0]       rd_data;
   logic [CSIZE-1:0] cmd;
   logic             cmd_ready = 1'b1;
   logic [3:0]       cmd_mid;
   logic [1:0]       cmd_proc_id;
   logic             scl_i = 1'b0;
   logic             sda_i = 1'b1;

   always #5 clock = ~clock;

   i2c_byte_seq #(.CSIZE(CSIZE), .TIMEOUT_CYC(TO)) dut (
      .clock(clock), .rst_n(rst_n), .op_vld(op_vld), .op(op), .op_data(op_data),
      .op_last(op_last), .op_mid(op_mid), .op_proc_id(op_proc_id),
      .op_ready(op_ready), .op_done(op_done), .rd_data(rd_data), .ack_err(ack_err),
      .timeout_err(timeout_err), .cmd_vld(cmd_vld), .cmd(cmd), .cmd_ready(cmd_ready),
      .cmd_mid(cmd_mid), .cmd_proc_id(cmd_proc_id), .scl_i(scl_i), .sda_i(sda_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Bus model state, written by the main sequence, read by the model.
   int         ready_mode = 0;   // 0 always ready, 1 toggling, 2 held low
   logic [7:0] slave_byte = 8'h00;
   logic       slave_ack  = 1'b0;
   logic [9:0] xlog[$];          // {cmd, cmd_mid, cmd_proc_id} per transfer

   initial begin
      logic [9:0] prev_rec;
      logic       prev_vld, prev_xfer, xfer;
      int         smp_cnt, rd_idx;
      prev_rec = '0; prev_vld = 1'b0; prev_xfer = 1'b0; smp_cnt = 0; rd_idx = 0;
      forever begin
         @(negedge clock);
         case (ready_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = ~cmd_ready;
            default: cmd_ready = 1'b0;
         endcase
         if (!rst_n) begin
            prev_vld = 1'b0; prev_xfer = 1'b0; smp_cnt = 0; rd_idx = 0; scl_i = 1'b0;
         end else begin
            if (prev_xfer)
               check("vld_drop_after_xfer", {31'd0, cmd_vld}, 32'd0);
            else if (prev_vld && cmd_vld)
               check("cmd_stable", {22'd0, cmd, cmd_mid, cmd_proc_id}, {22'd0, prev_rec});
            xfer = cmd_vld && cmd_ready;
            if (xfer) begin
               xlog.push_back({cmd, cmd_mid, cmd_proc_id});
               if (cmd == CMD_ACK) begin
                  sda_i = slave_ack; smp_cnt = 6;
               end else if (cmd == CMD_RD) begin
                  sda_i = (rd_idx < 8) ? slave_byte[7 - rd_idx] : 1'b1;
                  rd_idx++; smp_cnt = 6;
               end
               if (cmd != CMD_RD) rd_idx = 0;
            end
            prev_vld  = cmd_vld;
            prev_xfer = xfer;
            prev_rec  = {cmd, cmd_mid, cmd_proc_id};
            if (smp_cnt > 0) smp_cnt--;
            scl_i = (smp_cnt >= 1 && smp_cnt <= 3);
         end
      end
   end

   // Presents one op, pokes a stray request while busy, waits for op_done.
   task automatic run_op(input logic [1:0] o, input logic [7:0] d, input logic l,
                         input logic [3:0] mid, input logic [1:0] pid,
                         output bit done, output int cyc_vld);
      done = 1'b0; cyc_vld = 0;
      for (int k = 0; k < 50 && !op_ready; k++) @(negedge clock);
      check("op_ready_idle", {31'd0, op_ready}, 32'd1);
      op = o; op_data = d; op_last = l; op_mid = mid; op_proc_id = pid; op_vld = 1'b1;
      @(negedge clock);
      op = 2'd3; op_mid = 4'hF; op_data = 8'h00;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         if (cmd_vld) cyc_vld++;
         if (op_done) begin
            done = 1'b1;
            break;
         end
      end
      op_vld = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [7:0]  data;
      logic        last;
      logic [7:0]  sbyte;
      logic        sack;
      int          rmode;
      int          n_cmd;
      logic [35:0] cmds;     // first command in the top nibble
      logic [7:0]  exp_rd;
      logic        exp_ack;
   } vec_t;

   vec_t vecs[7];

   initial begin
      bit done;
      int cv, lstart, nlog;
      bit gap, found;
      logic [3:0] ec;

      vecs[0] = '{"start",    2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1,
                  {CMD_START, 32'h0}, 8'h00, 1'b0};
      vecs[1] = '{"write_a5", 2'd1, 8'hA5, 1'b0, 8'h00, 1'b0, 0, 9,
                  {CMD_1, CMD_0, CMD_1, CMD_0, CMD_0, CMD_1, CMD_0, CMD_L1, CMD_ACK}, 8'h00, 1'b0};
      vecs[2] = '{"write_3c", 2'd1, 8'h3C, 1'b0, 8'h00, 1'b1, 0, 9,
                  {CMD_0, CMD_0, CMD_1, CMD_1, CMD_1, CMD_1, CMD_0, CMD_L0, CMD_ACK}, 8'h00, 1'b1};
      vecs[3] = '{"read_5a",  2'd2, 8'h00, 1'b1, 8'h5A, 1'b0, 0, 9,
                  {CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_1}, 8'h5A, 1'b1};
      vecs[4] = '{"read_c3",  2'd2, 8'h00, 1'b0, 8'hC3, 1'b0, 1, 9,
                  {CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_RD, CMD_MACK}, 8'hC3, 1'b1};
      vecs[5] = '{"stop",     2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1,
                  {CMD_STOP, 32'h0}, 8'hC3, 1'b1};
      vecs[6] = '{"write_01", 2'd1, 8'h01, 1'b0, 8'h00, 1'b0, 1, 9,
                  {CMD_0, CMD_0, CMD_0, CMD_0, CMD_0, CMD_0, CMD_0, CMD_L1, CMD_ACK}, 8'hC3, 1'b0};

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst_op_ready",    {31'd0, op_ready},    32'd1);
      check("rst_cmd_vld",     {31'd0, cmd_vld},     32'd0);
      check("rst_op_done",     {31'd0, op_done},     32'd0);
      check("rst_rd_data",     {24'd0, rd_data},     32'd0);
      check("rst_ack_err",     {31'd0, ack_err},     32'd0);
      check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      check("rst_cmd",         {28'd0, cmd},         {28'd0, CMD_IDLE});
      check("rst_cmd_tags",    {26'd0, cmd_mid, cmd_proc_id}, 32'd0);
      rst_n = 1'b1;
      @(negedge clock);

      // Table-driven ops.
      for (int i = 0; i < 7; i++) begin
         ready_mode = vecs[i].rmode;
         slave_byte = vecs[i].sbyte;
         slave_ack  = vecs[i].sack;
         lstart     = xlog.size();
         run_op(vecs[i].op, vecs[i].data, vecs[i].last, 4'(i + 1), 2'(i), done, cv);
         check({vecs[i].name, "_done"}, {31'd0, done}, 32'd1);
         check({vecs[i].name, "_rd_data"}, {24'd0, rd_data}, {24'd0, vecs[i].exp_rd});
         check({vecs[i].name, "_ack_err"}, {31'd0, ack_err}, {31'd0, vecs[i].exp_ack});
         check({vecs[i].name, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
         nlog = xlog.size() - lstart;
         check({vecs[i].name, "_n_cmds"}, nlog, vecs[i].n_cmd);
         for (int k = 0; k < vecs[i].n_cmd && k < nlog; k++) begin
            ec = vecs[i].cmds[35 - 4*k -: 4];
            check($sformatf("%s_cmd%0d", vecs[i].name, k),
                  {22'd0, xlog[lstart + k]}, {22'd0, ec, 4'(i + 1), 2'(i)});
         end
         @(negedge clock);
         check({vecs[i].name, "_done_pulse_end"}, {31'd0, op_done}, 32'd0);
         check({vecs[i].name, "_ready_after"}, {31'd0, op_ready}, 32'd1);
      end

      // Reset while the 4th bit of a WRITE 0xF0 is presented.
      ready_mode = 0;
      slave_ack  = 1'b0;
      op = 2'd1; op_data = 8'hF0; op_last = 1'b0; op_mid = 4'h9; op_proc_id = 2'd1;
      op_vld = 1'b1;
      lstart = xlog.size();
      @(negedge clock);
      op_vld = 1'b0;
      gap = 1'b0; found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (xlog.size() - lstart == 3 && !cmd_vld) gap = 1'b1;
         if (gap && cmd_vld) begin
            found = 1'b1;
            break;
         end
      end
      check("midop_4th_bit_seen", {31'd0, found}, 32'd1);
      check("midop_4th_cmd", {28'd0, cmd}, {28'd0, CMD_1});
      rst_n = 1'b0;
      @(negedge clock);
      check("midop_rst_cmd_vld",  {31'd0, cmd_vld},  32'd0);
      check("midop_rst_op_ready", {31'd0, op_ready}, 32'd1);
      check("midop_rst_op_done",  {31'd0, op_done},  32'd0);
      check("midop_rst_rd_data",  {24'd0, rd_data},  32'd0);
      check("midop_rst_cmd",      {28'd0, cmd},      {28'd0, CMD_IDLE});
      check("midop_rst_tags",     {26'd0, cmd_mid, cmd_proc_id}, 32'd0);
      rst_n = 1'b1;
      @(negedge clock);
      lstart = xlog.size();
      run_op(2'd0, 8'h00, 1'b0, 4'h2, 2'd3, done, cv);
      check("post_rst_start_done", {31'd0, done}, 32'd1);
      check("post_rst_n_cmds", xlog.size() - lstart, 1);
      if (xlog.size() > lstart)
         check("post_rst_cmd", {22'd0, xlog[lstart]}, {22'd0, CMD_START, 4'h2, 2'd3});
      @(negedge clock);

`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
      // Bit engine never ready: watchdog aborts after TO cycles in ISSUE.
      ready_mode = 2;
      lstart = xlog.size();
      run_op(2'd0, 8'h00, 1'b0, 4'h1, 2'd0, done, cv);
      check("to_done",        {31'd0, done},        32'd1);
      check("to_timeout_err", {31'd0, timeout_err}, 32'd1);
      check("to_cmd_vld",     {31'd0, cmd_vld},     32'd0);
      check("to_issue_cycles", cv, TO);
      check("to_n_cmds", xlog.size() - lstart, 0);
      @(negedge clock);
      check("to_sticky", {31'd0, timeout_err}, 32'd1);
      ready_mode = 0;
      run_op(2'd0, 8'h00, 1'b0, 4'h1, 2'd0, done, cv);
      check("to_recover_done",  {31'd0, done},        32'd1);
      check("to_cleared",       {31'd0, timeout_err}, 32'd0);
      @(negedge clock);
`else
      // Without the watchdog a stalled bit engine is waited on indefinitely.
      ready_mode = 2;
      op = 2'd3; op_mid = 4'h4; op_proc_id = 2'd2; op_vld = 1'b1;
      @(negedge clock);
      op_vld = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (op_done) found = 1'b1;
      end
      check("stall_no_done",     {31'd0, found},       32'd0);
      check("stall_cmd_vld",     {31'd0, cmd_vld},     32'd1);
      check("stall_cmd",         {28'd0, cmd},         {28'd0, CMD_STOP});
      check("stall_timeout_err", {31'd0, timeout_err}, 32'd0);
      ready_mode = 0;
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         if (op_done) begin
            found = 1'b1;
            break;
         end
      end
      check("stall_release_done", {31'd0, found}, 32'd1);
      @(negedge clock);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_byte_seq.md
I2C_BYTE_SEQ -- requirements
Module: i2c_byte_seq

Interface
REQ-001 Parameters: CSIZE, default 4, width of the bit-command code; TIMEOUT_CYC, default 4096, watchdog limit in clock cycles.
REQ-002 Ports, clock and reset first:
- clock  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; clock is clock.
- op_vld  in  1  byte-operation request.
- op  in  2  operation code: 0 START, 1 WRITE, 2 READ, 3 STOP.
- op_data  in  8  write byte.
- op_last  in  1  READ only: 1 = NACK after the byte, 0 = MACK.
- op_mid  in  4  module ID tag.
- op_proc_id  in  2  process ID tag.
- op_ready  out  1  sequencer can accept an op.
- op_done  out  1  one-cycle op-complete pulse.
- rd_data  out  8  received byte.
- ack_err  out  1  slave NACK on last WRITE.
- timeout_err  out  1  watchdog abort flag.
- cmd_vld  out  1  bit-command valid.
- cmd  out  CSIZE  bit-command code, using parameter_package CMD_* constants.
- cmd_ready  in  1  downstream bit engine is idle.
- cmd_mid  out  4  module ID tag.
- cmd_proc_id  out  2  process ID tag.
- scl_i  in  1  bus SCL, asynchronous.
- sda_i  in  1  bus SDA, asynchronous.

Function
REQ-003 An op is accepted when op_vld && op_ready; op, op_data, op_last, op_mid and op_proc_id are latched in that cycle.
REQ-004 op_ready SHALL be 1 only in IDLE; ops presented while busy are ignored.
REQ-005 The latched op expands into this bit-command list:
- START -> CMD_START.
- STOP -> CMD_STOP.
- WRITE -> op_data[7:1] MSB-first as CMD_1/CMD_0, then op_data[0] as CMD_L1/CMD_L0, then CMD_ACK.
- READ -> 8x CMD_RD, then CMD_MACK if op_last=0, else CMD_1.
REQ-006 A command transfers when cmd_vld && cmd_ready. cmd_vld SHALL drop the cycle after a transfer and stay low for at least one cycle before the next command is presented.
REQ-007 cmd, cmd_mid and cmd_proc_id SHALL remain stable while cmd_vld=1.
REQ-008 scl_i and sda_i pass through 2-flop synchronizers.
REQ-009 A rising edge of synchronized SCL, while a sample is armed, captures synchronized SDA.
REQ-010 A sample is armed at transfer of CMD_RD or CMD_ACK. The next command SHALL NOT be issued until that sample is taken.
REQ-011 READ: bit k is shifted MSB-first into rd_data; rd_data is updated once, after the 8th sample.
REQ-012 WRITE: ack_err is set to the sampled ACK bit (1 = NACK); it holds until the next WRITE completes or reset.
REQ-013 op_done SHALL pulse one cycle after the last transfer, or after the ACK sample for WRITE; the FSM returns to IDLE in the same cycle.
REQ-014 FSM states and transitions:
- IDLE -> LOAD on accept.
- LOAD -> ISSUE.
- ISSUE (cmd_vld=1) -> WAIT_SMP on transfer of RD/ACK; -> NEXT on transfer of any other command.
- WAIT_SMP -> NEXT on sample.
- NEXT -> ISSUE if commands remain, else DONE.
- DONE -> IDLE.
REQ-015 A 4-bit bit index counts the commands issued within an op; it wraps to 0 in LOAD.
REQ-016 A simultaneous SCL rising edge and cmd transfer in the same cycle SHALL NOT arm-and-sample in that cycle; sampling uses only an already-armed flag.

Reset
REQ-017 rst_n=0 at any clock edge, including mid-op, forces:
- FSM to IDLE.
- op_ready=1 from the first post-reset cycle.
- cmd_vld=0, op_done=0.
- rd_data=0, ack_err=0, timeout_err=0.
- cmd=CMD_IDLE, cmd_mid=0, cmd_proc_id=0.
- Sample armed flag cleared; synchronizers set to 1.

Configuration
REQ-018 Macro I2C_BYTE_SEQ_TIMEOUT_EN:
- Defined: a watchdog counts cycles spent in ISSUE or WAIT_SMP and clears on every state change. On reaching TIMEOUT_CYC it sets timeout_err (sticky until the next accept), drops cmd_vld, pulses op_done and returns to IDLE.
- Undefined: no counter is built, timeout_err is tied to 0, and waits are unbounded.

Verification
REQ-019 START op, cmd_ready held 1 -> exactly one CMD_START transfer, then op_done one cycle later, op_ready=1.
REQ-020 WRITE 0xA5, slave drives SDA=0 at the ACK SCL rise -> commands 1,0,1,0,0,1,0,L1,ACK in that order; ack_err=0; op_done.
REQ-021 WRITE 0x3C, SDA=1 at the ACK rise -> last data command is CMD_L0; ack_err=1.
REQ-022 READ op_last=1, slave returns 0x5A -> 8x CMD_RD then CMD_1; rd_data=0x5A at op_done.
REQ-023 rst_n pulsed low during the 4th bit of a WRITE -> next cycle cmd_vld=0, op_ready=1; a new START op then completes normally.
REQ-024 With I2C_BYTE_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, cmd_ready held 0 -> timeout_err=1 after 16 cycles in ISSUE, op_done pulses, cmd_vld=0.
